// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, RUN/HALTED control FSM and a single
// output slot with a valid/ready handshake toward decode.
module instr_fetch #(
   parameter int                ADDR_W   = 6,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [1:0]        state_out,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] pc;
   logic              free;
   logic              capture;

   assign mem_addr  = pc;
   assign state_out = state;
   assign free      = !instr_valid || instr_ready;

   // NOTE: non-blocking assignments for every register so all state updates
   // see pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            if (halt) begin
               state_next = HALTED;
            end else begin
               capture = free && !redirect_valid;
            end
         end
         HALTED: begin
            if (start) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Redirect outranks capture; a handshake finishing alongside it is delivered.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc          <= redirect_addr;
         instr_valid <= 1'b0;
      end else if (capture) begin
         instr_out   <= mem_data;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
         pc          <= pc + PC_STEP;
         if (fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
         end
      end else if (instr_valid && instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed stimulus queues the expected
// deliveries, a negedge monitor compares every completed handshake.
module tb_instr_fetch;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic              halt;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic [1:0]        state_out;
   logic [15:0]       fetch_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .state_out      (state_out),
      .fetch_count    (fetch_count)
   );

   // Code memory: word at address n is 0x1000 + n.
   assign mem_data = 16'h1000 + {10'b0, mem_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_fetch(input int pc);
      exp_t e;
      e.pc   = ADDR_W'(pc);
      e.data = 16'h1000 + 16'(pc);
      sb_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc %0d with empty scoreboard", instr_pc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("deliver_pc", instr_pc, e.pc);
            check("deliver_data", instr_out, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; halt = 1'b0;
      redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
      tick(2);
      check("rst_state", state_out, 2'b00);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_out", instr_out, 16'h0);
      check("rst_ipc", instr_pc, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_count", fetch_count, 0);
      rst = 1'b0;
      tick(2);
      check("idle_valid", instr_valid, 1'b0);
      check("idle_addr", mem_addr, 0);

      // Start, full-rate fetch of 0,1,2..., then back-pressure at instr_pc=5.
      for (int i = 0; i < 6; i++) expect_fetch(i);
      instr_ready = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      check("start_state", state_out, 2'b01);
      check("start_valid_lat", instr_valid, 1'b0);
      tick(1);
      check("first_valid", instr_valid, 1'b1);
      check("first_pc", instr_pc, 0);
      check("first_data", instr_out, 16'h1000);
      tick(2);
      check("third_pc", instr_pc, 2);
      check("count3", fetch_count, 3);
      tick(3);
      check("pc5", instr_pc, 5);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("stall_pc", instr_pc, 5);
         check("stall_data", instr_out, 16'h1005);
         check("stall_addr", mem_addr, 6);
         check("stall_valid", instr_valid, 1'b1);
      end
      instr_ready = 1'b1;
      tick(1);
      check("after_stall_pc", instr_pc, 6);

      // Redirect to 40 while instruction 6 is stalled: 6 is flushed.
      expect_fetch(40); expect_fetch(41);
      instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 6'd40;
      tick(1);
      redirect_valid = 1'b0;
      check("redir_valid", instr_valid, 1'b0);
      check("redir_addr", mem_addr, 40);
      check("redir_state", state_out, 2'b01);
      instr_ready = 1'b1;
      tick(1);
      check("redir_pc40", instr_pc, 40);
      tick(1);
      check("redir_pc41", instr_pc, 41);

      // Redirect to 63 (41 is delivered in the same cycle), then wrap.
      expect_fetch(63); expect_fetch(0); expect_fetch(1);
      redirect_valid = 1'b1; redirect_addr = 6'd63;
      tick(1);
      redirect_valid = 1'b0;
      tick(1);
      check("wrap_pc63", instr_pc, 63);
      check("wrap_addr", mem_addr, 0);
      tick(1);
      check("wrap_pc0", instr_pc, 0);
      check("wrap_data0", instr_out, 16'h1000);
      tick(1);
      check("wrap_pc1", instr_pc, 1);

      // Halt with a pending instruction, release it, then restart.
      instr_ready = 1'b0; halt = 1'b1;
      tick(1);
      halt = 1'b0;
      check("halt_state", state_out, 2'b10);
      check("halt_held_valid", instr_valid, 1'b1);
      check("halt_held_pc", instr_pc, 1);
      tick(2);
      check("halted_pc", instr_pc, 1);
      check("halted_addr", mem_addr, 2);
      check("halted_count", fetch_count, 12);
      instr_ready = 1'b1;
      tick(1);
      check("halted_drain", instr_valid, 1'b0);
      check("halted_state", state_out, 2'b10);
      expect_fetch(2); expect_fetch(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("resume_state", state_out, 2'b01);
      check("resume_valid", instr_valid, 1'b0);
      tick(1);
      check("resume_pc2", instr_pc, 2);
      tick(1);
      check("resume_pc3", instr_pc, 3);

      // halt+start together: halt wins in RUN, start wins in HALTED.
      halt = 1'b1; start = 1'b1;
      tick(1);
      check("hs_run_state", state_out, 2'b10);
      check("hs_run_valid", instr_valid, 1'b0);
      check("hs_run_addr", mem_addr, 4);
      tick(1);
      halt = 1'b0; start = 1'b0;
      check("hs_halted_state", state_out, 2'b01);
      tick(1);
      check("hs_pc4", instr_pc, 4);
      check("hs_valid", instr_valid, 1'b1);

      // Reset with instruction 4 pending drops it.
      instr_ready = 1'b0; rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_valid", instr_valid, 1'b0);
      check("mid_rst_state", state_out, 2'b00);
      check("mid_rst_count", fetch_count, 0);

      // Ten fetches, then reset overriding start/halt/redirect.
      for (int i = 0; i < 9; i++) expect_fetch(i);
      instr_ready = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      check("count10", fetch_count, 10);
      check("count10_pc", instr_pc, 9);
      rst = 1'b1; start = 1'b1; halt = 1'b1;
      redirect_valid = 1'b1; redirect_addr = 6'd33; instr_ready = 1'b0;
      tick(1);
      rst = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      check("rst2_state", state_out, 2'b00);
      check("rst2_valid", instr_valid, 1'b0);
      check("rst2_addr", mem_addr, 0);
      check("rst2_count", fetch_count, 0);

      // Redirect in IDLE moves the PC but neither the state nor fetching.
      redirect_valid = 1'b1; redirect_addr = 6'd20;
      tick(1);
      redirect_valid = 1'b0;
      check("idle_redir_state", state_out, 2'b00);
      check("idle_redir_addr", mem_addr, 20);
      tick(2);
      check("idle_redir_hold", mem_addr, 20);
      check("idle_redir_valid", instr_valid, 1'b0);
      check("idle_redir_count", fetch_count, 0);

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
